// File: rtl/ks_pkg.sv
// ks_pkg: FSM encoding and default widths shared by the keystream deserializer and cipher datapath
package ks_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, STALL = 2'd2} ks_state_e;
  localparam int KS_WORD_W = 8;
  localparam int KS_CNT_W = 16;
endpackage

// File: rtl/keystream_deser_if.sv
// keystream_deser_if: valid/ready keystream word bus
interface keystream_deser_if #(parameter int WORD_W = 8) ();
  logic [WORD_W-1:0] Word_out;
  logic              Word_valid;
  logic              Word_ready;
  modport master (output Word_out, Word_valid, input Word_ready);
  modport slave (input Word_out, Word_valid, output Word_ready);
endinterface

// File: rtl/ks_out_slot.sv
// ks_out_slot: single-entry valid/ready holding register for the assembled word
module ks_out_slot #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  always_comb begin
    data_d  = load ? din : data_q;
    valid_d = clr ? 1'b0 : load ? 1'b1 : (valid_q && ready) ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign dout  = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/keystream_deser.sv
// keystream_deser: packs NFSR serial bits MSB-first into words on a valid/ready bus.
// KS_WORD_CNT_EN adds the Word_cnt transfer counter port.
module keystream_deser import ks_pkg::*; #(
  parameter int WORD_W = KS_WORD_W,
  parameter int CNT_W  = KS_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic En,
  input  logic Clear,
  input  logic Ser_in,
  output logic Shift_req,
  keystream_deser_if.master wb
`ifdef KS_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0] Word_cnt
`endif
);
  localparam int BW = $clog2(WORD_W + 1);
  ks_state_e         state_q, state_d;
  logic [WORD_W-1:0] asm_q, asm_d, load_data;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              load, can_load;
  assign can_load  = !wb.Word_valid || wb.Word_ready;
  assign Shift_req = (state_q == COLLECT) && !Clear;
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    load_data = asm_q;
    if (Clear) begin
      state_d   = IDLE;
      asm_d     = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = En ? COLLECT : IDLE;
        COLLECT: begin
          asm_d     = {asm_q[WORD_W-2:0], Ser_in};
          load_data = asm_d;
          if (bit_cnt_q == BW'(WORD_W - 1)) begin
            load      = can_load;
            bit_cnt_d = can_load ? '0 : BW'(WORD_W);
            state_d   = !can_load ? STALL : En ? COLLECT : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = En ? COLLECT : IDLE;
          end
        end
        STALL: if (wb.Word_ready) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          state_d   = En ? COLLECT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      asm_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
  ks_out_slot #(.W(WORD_W)) u_slot (
    .clk   (clk),
    .rst   (rst),
    .clr   (Clear),
    .load  (load),
    .ready (wb.Word_ready),
    .din   (load_data),
    .dout  (wb.Word_out),
    .valid (wb.Word_valid)
  );
`ifdef KS_WORD_CNT_EN
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  always_comb wcnt_d = Clear ? '0 : (wb.Word_valid && wb.Word_ready) ? wcnt_q + 1'b1 : wcnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt_q <= '0;
    else wcnt_q <= wcnt_d;
  end
  assign Word_cnt = wcnt_q;
`endif
endmodule
